// File: rtl/pmem_responder.sv
// Line-granular memory responder for the L2 burst port: one request at a time,
// fixed latency to a single-cycle resp, with saturating read/write counters.
module pmem_responder #(
   parameter int LATENCY   = 10,
   parameter int LINE_BITS = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         read,
   input  logic         write,
   input  logic [15:0]  address,
   input  logic [127:0] wdata,
   output logic         resp,
   output logic [127:0] rdata,
   output logic         proto_err,
   output logic [15:0]  rd_count,
   output logic [15:0]  wr_count
);

   localparam int         NLINES    = 1 << LINE_BITS;
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_RESP    = 2'd2;
   localparam logic [7:0] WAIT_LOAD = 8'((LATENCY >= 2) ? (LATENCY - 2) : 0);

   logic [1:0]           state_q, state_d;
   logic [7:0]           lat_q, lat_d;
   logic                 op_wr_q, op_wr_d;
   logic [LINE_BITS-1:0] idx_q, idx_d;
   logic [127:0]         wbuf_q, wbuf_d;
   logic [127:0]         rdata_q, rdata_d;
   logic                 perr_q, perr_d;
   logic [15:0]          rd_cnt_q, rd_cnt_d;
   logic [15:0]          wr_cnt_q, wr_cnt_d;
   logic [127:0]         mem_q [NLINES];

   logic [LINE_BITS-1:0] addr_idx;
   logic [LINE_BITS-1:0] rd_idx;
   logic                 accept;
   logic                 unused_addr;

   assign addr_idx    = address[LINE_BITS+3:4];
   assign unused_addr = ^{address[15:LINE_BITS+4], address[3:0]};
   assign accept      = (state_q == S_IDLE) && (read || write);
   // With LATENCY=1 the array is read in the acceptance cycle, before idx_q is loaded.
   assign rd_idx      = (state_q == S_IDLE) ? addr_idx : idx_q;

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      op_wr_d  = op_wr_q;
      idx_d    = idx_q;
      wbuf_d   = wbuf_q;
      rdata_d  = rdata_q;
      perr_d   = perr_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_wr_d = write;
               idx_d   = addr_idx;
               wbuf_d  = wdata;
               if (read && write) perr_d = 1'b1;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
                  if (!write) rdata_d = mem_q[rd_idx];
               end else begin
                  state_d = S_WAIT;
                  lat_d   = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (lat_q == 8'd0) begin
               state_d = S_RESP;
               if (!op_wr_q) rdata_d = mem_q[rd_idx];
            end else begin
               lat_d = lat_q - 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            if (op_wr_q) begin
               if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
               if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         lat_q    <= 8'd0;
         op_wr_q  <= 1'b0;
         idx_q    <= '0;
         wbuf_q   <= '0;
         rdata_q  <= '0;
         perr_q   <= 1'b0;
         rd_cnt_q <= 16'd0;
         wr_cnt_q <= 16'd0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         op_wr_q  <= op_wr_d;
         idx_q    <= idx_d;
         wbuf_q   <= wbuf_d;
         rdata_q  <= rdata_d;
         perr_q   <= perr_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   // Line commit happens on the edge leaving RESP so an immediately following read sees it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NLINES; i++) mem_q[i] <= '0;
      end else if ((state_q == S_RESP) && op_wr_q) begin
         mem_q[idx_q] <= wbuf_q;
      end
   end

   assign resp      = (state_q == S_RESP);
   assign rdata     = rdata_q;
   assign proto_err = perr_q;
   assign rd_count  = rd_cnt_q;
   assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: two instances (LATENCY 4 and 1) driven by directed
// requests; expected resp cycle and rdata are queued and checked by monitors.
module tb_pmem_responder;

   typedef struct {
      int           cyc;
      logic [127:0] rdata;
   } exp_t;

   logic         clk = 1'b0;
   logic         rstn [2];
   logic         rq   [2];
   logic         wq   [2];
   logic [15:0]  aq   [2];
   logic [127:0] dq   [2];
   logic         resp_o  [2];
   logic [127:0] rdata_o [2];
   logic         perr_o  [2];
   logic [15:0]  rdc_o   [2];
   logic [15:0]  wrc_o   [2];

   int           cyc = 0;
   int           n_chk = 0;
   int           n_err = 0;
   exp_t         q4 [$];
   exp_t         q1 [$];
   logic [127:0] last_rd [2];
   int           exp_rd [2];
   int           exp_wr [2];

   localparam logic [127:0] DA = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_0001;
   localparam logic [127:0] DD = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
   localparam logic [127:0] DE = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] DF = 128'hF0F0_0F0F_CAFE_BABE_0000_FFFF_1234_5678;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pmem_responder #(.LATENCY(4), .LINE_BITS(6)) u_dut4 (
      .clk(clk), .rst_n(rstn[0]), .read(rq[0]), .write(wq[0]), .address(aq[0]),
      .wdata(dq[0]), .resp(resp_o[0]), .rdata(rdata_o[0]), .proto_err(perr_o[0]),
      .rd_count(rdc_o[0]), .wr_count(wrc_o[0]));

   pmem_responder #(.LATENCY(1), .LINE_BITS(6)) u_dut1 (
      .clk(clk), .rst_n(rstn[1]), .read(rq[1]), .write(wq[1]), .address(aq[1]),
      .wdata(dq[1]), .resp(resp_o[1]), .rdata(rdata_o[1]), .proto_err(perr_o[1]),
      .rd_count(rdc_o[1]), .wr_count(wrc_o[1]));

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic mon(input int sel, input exp_t e, input bit have);
      string tag;
      tag = (sel == 0) ? "lat4" : "lat1";
      if (!have) begin
         chk({tag, " unexpected_resp"}, 128'(cyc), 128'hFFFF_FFFF);
      end else begin
         chk({tag, " resp_cycle"}, 128'(cyc), 128'(e.cyc));
         chk({tag, " rdata"}, rdata_o[sel], e.rdata);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (resp_o[0] === 1'b1) begin
         if (q4.size() > 0) begin e = q4.pop_front(); mon(0, e, 1'b1); end
         else mon(0, e, 1'b0);
      end
      if (resp_o[1] === 1'b1) begin
         if (q1.size() > 0) begin e = q1.pop_front(); mon(1, e, 1'b1); end
         else mon(1, e, 1'b0);
      end
   end

   // Issues one request starting after a rising edge; returns just after the edge leaving RESP.
   task automatic req(input int sel, input bit rd, input bit wr, input logic [15:0] a,
                      input logic [127:0] d, input logic [127:0] exp_data, input bit wiggle,
                      input string nm);
      exp_t e;
      bit   got;
      int   lat;
      lat = (sel == 0) ? 4 : 1;
      rq[sel] = rd;
      wq[sel] = wr;
      aq[sel] = a;
      dq[sel] = d;
      e.cyc   = cyc + lat;
      e.rdata = wr ? last_rd[sel] : exp_data;
      if (sel == 0) q4.push_back(e); else q1.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wiggle && i == 2) begin
            aq[sel] = 16'h0020;
            dq[sel] = ~d;
         end
         if (resp_o[sel] === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk({nm, " resp_timeout"}, 128'd0, 128'd1);
      @(posedge clk);
      #1;
      rq[sel] = 1'b0;
      wq[sel] = 1'b0;
      if (wr) begin
         if (exp_wr[sel] < 65535) exp_wr[sel]++;
      end else begin
         if (exp_rd[sel] < 65535) exp_rd[sel]++;
         last_rd[sel] = exp_data;
      end
      chk({nm, " rd_count"}, 128'(rdc_o[sel]), 128'(exp_rd[sel]));
      chk({nm, " wr_count"}, 128'(wrc_o[sel]), 128'(exp_wr[sel]));
   endtask

   task automatic chk_reset_state(input int sel, input string nm);
      chk({nm, " resp"}, 128'(resp_o[sel]), 128'd0);
      chk({nm, " rdata"}, rdata_o[sel], 128'd0);
      chk({nm, " proto_err"}, 128'(perr_o[sel]), 128'd0);
      chk({nm, " rd_count"}, 128'(rdc_o[sel]), 128'd0);
      chk({nm, " wr_count"}, 128'(wrc_o[sel]), 128'd0);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         rstn[s] = 1'b0; rq[s] = 1'b0; wq[s] = 1'b0; aq[s] = '0; dq[s] = '0;
         last_rd[s] = '0; exp_rd[s] = 0; exp_wr[s] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state(0, "reset4");
      chk_reset_state(1, "reset1");
      @(negedge clk);
      rstn[0] = 1'b1;
      rstn[1] = 1'b1;
      @(posedge clk);
      #1;

      // Write with inputs disturbed mid-WAIT, then read back.
      req(0, 1'b0, 1'b1, 16'h1230, DA, '0, 1'b1, "wr_1230");
      req(0, 1'b1, 1'b0, 16'h1230, '0, DA, 1'b0, "rd_1230");

      // Aliasing modulo 64 lines.
      req(0, 1'b0, 1'b1, 16'h0010, DD, '0, 1'b0, "wr_0010");
      req(0, 1'b1, 1'b0, 16'h0410, '0, DD, 1'b0, "rd_0410_alias");
      req(0, 1'b1, 1'b0, 16'h0020, '0, '0, 1'b0, "rd_0020_empty");

      // read and write together: write wins, proto_err sticks.
      req(0, 1'b1, 1'b1, 16'h0040, DE, '0, 1'b0, "rw_0040");
      chk("proto_err_set", 128'(perr_o[0]), 128'd1);
      req(0, 1'b1, 1'b0, 16'h0040, '0, DE, 1'b0, "rd_0040");
      chk("proto_err_sticky", 128'(perr_o[0]), 128'd1);

      // Reset during WAIT of a write abandons it and clears everything.
      rq[0] = 1'b0; wq[0] = 1'b1; aq[0] = 16'h0050; dq[0] = DF;
      @(negedge clk);
      @(negedge clk);
      rstn[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      wq[0] = 1'b0;
      @(negedge clk);
      rstn[0] = 1'b1;
      exp_rd[0] = 0; exp_wr[0] = 0; last_rd[0] = '0;
      chk_reset_state(0, "midop_reset");
      @(posedge clk);
      #1;
      req(0, 1'b1, 1'b0, 16'h0050, '0, '0, 1'b0, "rd_0050_after_rst");
      req(0, 1'b1, 1'b0, 16'h1230, '0, '0, 1'b0, "rd_1230_after_rst");

      // LATENCY=1: back-to-back reads, write then immediate read of same line.
      req(1, 1'b1, 1'b0, 16'h0000, '0, '0, 1'b0, "l1_rd_a");
      req(1, 1'b1, 1'b0, 16'h0000, '0, '0, 1'b0, "l1_rd_b");
      req(1, 1'b0, 1'b1, 16'h0030, DF, '0, 1'b0, "l1_wr_0030");
      req(1, 1'b1, 1'b0, 16'h0030, '0, DF, 1'b0, "l1_rd_0030");

      // Saturation of the read counter.
      force u_dut1.rd_cnt_q = 16'hFFFE;
      @(posedge clk);
      #1;
      release u_dut1.rd_cnt_q;
      exp_rd[1] = 65534;
      req(1, 1'b1, 1'b0, 16'h0030, '0, DF, 1'b0, "l1_sat_a");
      req(1, 1'b1, 1'b0, 16'h0000, '0, '0, 1'b0, "l1_sat_b");
      repeat (3) @(posedge clk);
      #1;
      chk("rd_count_stays_sat", 128'(rdc_o[1]), 128'hFFFF);

      repeat (5) @(posedge clk);
      #1;
      chk("queue4_drained", 128'(q4.size()), 128'd0);
      chk("queue1_drained", 128'(q1.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
